// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: instruction handshake, ALU, data-memory and debug register-read bundle.
// master is the issue controller, slave is the surrounding ALU/memory/sender environment.
interface alu_issue_ctrl_if #(parameter int ADDR_W = 8);
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       instr;
    logic [2:0]        alu_op;
    logic [31:0]       alu_a;
    logic [31:0]       alu_b;
    logic [31:0]       alu_res;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              done;
    logic              err;
    logic [2:0]        rf_sel;
    logic [31:0]       rf_data;
    modport master (
        input  in_valid, instr, alu_res, mem_rdata, rf_sel,
        output in_ready, alu_op, alu_a, alu_b, mem_addr, mem_rd, mem_wr, mem_wdata, done, err, rf_data
    );
    modport slave (
        output in_valid, instr, alu_res, mem_rdata, rf_sel,
        input  in_ready, alu_op, alu_a, alu_b, mem_addr, mem_rd, mem_wr, mem_wdata, done, err, rf_data
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues 16-bit instructions to an external combinational ALU over an 8x32 register
// file, sequencing loads/stores through data memory and multi-cycle dot products into an accumulator.
module alu_issue_ctrl #(parameter int ADDR_W = 8) (
    input logic clk,
    input logic rst_n,
    alu_issue_ctrl_if.master bus
);
    localparam logic [2:0] OP_ADD = 3'b000, OP_MUL = 3'b001, OP_LDR = 3'b100,
                           OP_STR = 3'b101, OP_MOV = 3'b110, OP_DPRO = 3'b111;
    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MEM, S_DOT, S_WB} state_t;
    state_t      r_state;
    logic [15:0] r_instr;
    logic [31:0] r_rf [8];
    logic [31:0] r_acc;
    logic [3:0]  r_idx;
    logic        r_done;
    logic        r_err;
    logic [2:0]  w_op, w_rd, w_rs1, w_rs2, w_ia, w_ib;
    logic [3:0]  w_imm;
    logic        w_arith, w_mem;
    assign {w_op, w_rd, w_rs1, w_rs2, w_imm} = r_instr;
    assign w_ia = w_rs1 + r_idx[2:0];
    assign w_ib = w_rs2 + r_idx[2:0];
    assign w_arith = (w_op == OP_ADD) || (w_op == OP_MUL) || (w_op == OP_MOV);
    assign w_mem = (w_op == OP_LDR) || (w_op == OP_STR);
    assign bus.in_ready = (r_state == S_IDLE);
    assign bus.done = r_done;
    assign bus.err = r_err;
    assign bus.rf_data = r_rf[bus.rf_sel];
    // Illegal ops spend their EXEC cycle with the ALU and memory ports parked at idle values.
    always_comb begin
        bus.alu_op = '0;
        bus.alu_a = '0;
        bus.alu_b = '0;
        bus.mem_addr = '0;
        bus.mem_rd = 1'b0;
        bus.mem_wr = 1'b0;
        bus.mem_wdata = '0;
        if (r_state == S_EXEC && (w_arith || w_mem)) begin
            bus.alu_op = w_op;
            bus.alu_a = r_rf[w_rs1];
            bus.alu_b = w_mem ? {28'b0, w_imm} : r_rf[w_rs2];
            bus.mem_addr = w_mem ? bus.alu_res[ADDR_W-1:0] : '0;
            bus.mem_rd = (w_op == OP_LDR);
            bus.mem_wr = (w_op == OP_STR);
            bus.mem_wdata = (w_op == OP_STR) ? r_rf[w_rd] : '0;
        end
        if (r_state == S_DOT) begin
            bus.alu_op = OP_DPRO;
            bus.alu_a = r_rf[w_ia];
            bus.alu_b = r_rf[w_ib];
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_instr <= '0;
            r_acc <= '0;
            r_idx <= '0;
            r_done <= 1'b0;
            r_err <= 1'b0;
            for (int k = 0; k < 8; k++) r_rf[k] <= '0;
        end else begin
            r_done <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: if (bus.in_valid) begin
                    r_instr <= bus.instr;
                    r_acc <= '0;
                    r_idx <= '0;
                    r_state <= (bus.instr[15:13] == OP_DPRO) ? S_DOT : S_EXEC;
                end
                S_EXEC: begin
                    r_state <= (w_op == OP_LDR) ? S_MEM : S_IDLE;
                    r_done <= (w_op != OP_LDR);
                    r_err <= !(w_arith || w_mem);
                    if (w_arith) r_rf[w_rd] <= bus.alu_res;
                end
                S_MEM: begin
                    r_rf[w_rd] <= bus.mem_rdata;
                    r_state <= S_IDLE;
                    r_done <= 1'b1;
                end
                S_DOT: begin
                    r_acc <= r_acc + bus.alu_res;
                    r_idx <= r_idx + 4'd1;
                    if (r_idx == w_imm) r_state <= S_WB;
                end
                S_WB: begin
                    r_rf[w_rd] <= r_acc;
                    r_state <= S_IDLE;
                    r_done <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: drives alu_issue_ctrl with an ALU and memory model, checking against a register-level reference.
module tb_alu_issue_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    alu_issue_ctrl_if #(.ADDR_W(8)) bus ();
    alu_issue_ctrl #(.ADDR_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int vectors = 0;
    int miscompares = 0;
    logic [31:0] mem [256];
    logic [31:0] ref_rf [8];
    int rd_cnt = 0, wr_cnt = 0, done_cnt = 0;
    logic [7:0] last_waddr;
    logic [31:0] last_wdata;
    always_comb begin
        case (bus.alu_op)
            3'b000, 3'b100, 3'b101: bus.alu_res = bus.alu_a + bus.alu_b;
            3'b001, 3'b111: bus.alu_res = bus.alu_a * bus.alu_b;
            3'b110: bus.alu_res = bus.alu_a;
            default: bus.alu_res = '0;
        endcase
    end
    always @(posedge clk) if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
    always @(negedge clk) begin
        if (bus.mem_rd) rd_cnt++;
        if (bus.done) done_cnt++;
        if (bus.mem_wr) begin
            wr_cnt++;
            last_waddr = bus.mem_addr;
            last_wdata = bus.mem_wdata;
        end
    end
    function automatic logic [15:0] mk(input logic [2:0] op, rd, rs1, rs2, input logic [3:0] imm);
        return {op, rd, rs1, rs2, imm};
    endfunction
    // Issues one instruction and returns edges from accept to done (-1 on timeout).
    task automatic run(input logic [15:0] ins, output int lat, output logic e);
        int w = 0;
        while (!bus.in_ready && w < 50) begin @(posedge clk); #1; w++; end
        bus.instr = ins;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = -1;
        e = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (bus.done) begin lat = c; e = bus.err; break; end
        end
    endtask
    task automatic load_reg(input logic [2:0] rd, input logic [31:0] val);
        int lat;
        logic e;
        mem[ref_rf[0][7:0]] = val;
        run(mk(3'b100, rd, 3'd0, 3'd0, 4'd0), lat, e);
        ref_rf[rd] = val;
    endtask
    task automatic test_reset;
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl got ready=%b done=%b err=%b exp 1 0 0", bus.in_ready, bus.done, bus.err);
        end
        vectors++;
        if ({bus.alu_op, bus.alu_a, bus.alu_b, bus.mem_addr, bus.mem_rd, bus.mem_wr, bus.mem_wdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got op=%h a=%h b=%h addr=%h rd=%b wr=%b exp all zero",
                     bus.alu_op, bus.alu_a, bus.alu_b, bus.mem_addr, bus.mem_rd, bus.mem_wr);
        end
        for (int i = 0; i < 8; i++) begin
            ref_rf[i] = '0;
            bus.rf_sel = 3'(i); #1;
            vectors++;
            if (bus.rf_data !== 32'd0) begin miscompares++; $display("FAIL reset_rf R%0d got=%h exp=0", i, bus.rf_data); end
        end
    endtask
    task automatic test_load;
        int lat, r0;
        logic e;
        for (int k = 7; k >= 0; k--) begin
            r0 = rd_cnt;
            run(mk(3'b100, 3'(k), 3'd0, 3'd0, 4'(k)), lat, e);
            ref_rf[k] = 32'(k + 1);
            vectors++;
            if (lat !== 2 || rd_cnt - r0 !== 1) begin
                miscompares++;
                $display("FAIL load_timing k=%0d got lat=%0d rd_cycles=%0d exp lat=2 rd_cycles=1", k, lat, rd_cnt - r0);
            end
        end
        for (int i = 0; i < 8; i++) begin
            bus.rf_sel = 3'(i); #1;
            vectors++;
            if (bus.rf_data !== ref_rf[i]) begin miscompares++; $display("FAIL load R%0d got=%h exp=%h", i, bus.rf_data, ref_rf[i]); end
        end
    endtask
    task automatic test_add_str;
        int lat, w0, r0;
        logic e;
        run(mk(3'b000, 3'd0, 3'd1, 3'd2, 4'd0), lat, e);
        bus.rf_sel = 3'd0; #1;
        vectors++;
        if (lat !== 1 || bus.rf_data !== 32'd5) begin
            miscompares++;
            $display("FAIL add got lat=%0d R0=%h exp lat=1 R0=5", lat, bus.rf_data);
        end
        ref_rf[0] = 32'd5;
        w0 = wr_cnt;
        r0 = rd_cnt;
        run(mk(3'b101, 3'd0, 3'd3, 3'd0, 4'd2), lat, e);
        vectors++;
        if (lat !== 1 || wr_cnt - w0 !== 1 || rd_cnt != r0 || last_waddr !== 8'd6 || last_wdata !== 32'd5) begin
            miscompares++;
            $display("FAIL str got lat=%0d wr=%0d addr=%h data=%h exp lat=1 wr=1 addr=06 data=5",
                     lat, wr_cnt - w0, last_waddr, last_wdata);
        end
        mem[6] = 32'd5;
        load_reg(3'd0, 32'd1);
    endtask
    task automatic test_dpro;
        int lat, d0;
        logic ready_mid;
        bus.instr = mk(3'b111, 3'd7, 3'd0, 3'd4, 4'd3);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = -1;
        ready_mid = 1'b1;
        d0 = done_cnt;
        for (int c = 1; c <= 40; c++) begin
            if (c == 2) begin bus.instr = mk(3'b000, 3'd5, 3'd0, 3'd0, 4'd0); bus.in_valid = 1'b1; ready_mid = bus.in_ready; end
            if (c == 3) bus.in_valid = 1'b0;
            @(posedge clk); #1;
            if (bus.done) begin lat = c; break; end
        end
        repeat (4) @(posedge clk);
        #1;
        ref_rf[7] = 32'd70;
        vectors++;
        if (lat !== 5 || ready_mid !== 1'b0 || done_cnt - d0 !== 1) begin
            miscompares++;
            $display("FAIL dpro_timing got lat=%0d ready_mid=%b dones=%0d exp lat=5 ready_mid=0 dones=1", lat, ready_mid, done_cnt - d0);
        end
        for (int i = 0; i < 8; i++) begin
            bus.rf_sel = 3'(i); #1;
            vectors++;
            if (bus.rf_data !== ref_rf[i]) begin miscompares++; $display("FAIL dpro R%0d got=%h exp=%h", i, bus.rf_data, ref_rf[i]); end
        end
    endtask
    task automatic test_wrap;
        int lat;
        logic e;
        load_reg(3'd7, 32'd8);
        run(mk(3'b111, 3'd6, 3'd6, 3'd6, 4'd2), lat, e);
        bus.rf_sel = 3'd6; #1;
        vectors++;
        if (lat !== 4 || bus.rf_data !== 32'd114) begin
            miscompares++;
            $display("FAIL dpro_wrap got lat=%0d R6=%0d exp lat=4 R6=114", lat, bus.rf_data);
        end
        ref_rf[6] = 32'd114;
    endtask
    task automatic test_overflow;
        int lat;
        logic e;
        load_reg(3'd1, 32'h0001_0000);
        load_reg(3'd2, 32'h0001_0000);
        run(mk(3'b001, 3'd3, 3'd1, 3'd2, 4'd0), lat, e);
        bus.rf_sel = 3'd3; #1;
        vectors++;
        if (bus.rf_data !== 32'd0) begin miscompares++; $display("FAIL mul_wrap got=%h exp=00000000", bus.rf_data); end
        load_reg(3'd1, 32'h7FFF_FFFF);
        load_reg(3'd2, 32'd1);
        run(mk(3'b000, 3'd3, 3'd1, 3'd2, 4'd0), lat, e);
        bus.rf_sel = 3'd3; #1;
        vectors++;
        if (bus.rf_data !== 32'h8000_0000) begin miscompares++; $display("FAIL add_wrap got=%h exp=80000000", bus.rf_data); end
        ref_rf[3] = 32'h8000_0000;
    endtask
    task automatic test_illegal;
        int lat, r0, w0;
        logic e;
        for (int k = 2; k <= 3; k++) begin
            r0 = rd_cnt;
            w0 = wr_cnt;
            run(mk(3'(k), 3'd4, 3'd1, 3'd2, 4'd5), lat, e);
            vectors++;
            if (lat !== 1 || e !== 1'b1 || rd_cnt != r0 || wr_cnt != w0) begin
                miscompares++;
                $display("FAIL illegal op=%0d got lat=%0d err=%b strobes=%0d exp lat=1 err=1 strobes=0", k, lat, e, rd_cnt - r0 + wr_cnt - w0);
            end
            @(posedge clk); #1;
            vectors++;
            if (bus.done !== 1'b0 || bus.err !== 1'b0) begin
                miscompares++;
                $display("FAIL illegal_pulse got done=%b err=%b exp 0 0", bus.done, bus.err);
            end
        end
        for (int i = 0; i < 8; i++) begin
            bus.rf_sel = 3'(i); #1;
            vectors++;
            if (bus.rf_data !== ref_rf[i]) begin miscompares++; $display("FAIL illegal R%0d got=%h exp=%h", i, bus.rf_data, ref_rf[i]); end
        end
    endtask
    task automatic test_random;
        int lat, exp_lat, r0, w0;
        logic e;
        logic [2:0] op, rd, rs1, rs2;
        logic [3:0] imm;
        logic [7:0] addr;
        logic [31:0] expv;
        for (int i = 0; i < 8; i++) load_reg(3'(i), $urandom);
        for (int n = 0; n < 40; n++) begin
            {op, rd, rs1, rs2, imm} = 16'($urandom);
            addr = 8'(ref_rf[rs1] + 32'(imm));
            expv = '0;
            case (op)
                3'b000: expv = ref_rf[rs1] + ref_rf[rs2];
                3'b001: expv = ref_rf[rs1] * ref_rf[rs2];
                3'b110: expv = ref_rf[rs1];
                3'b100: expv = mem[addr];
                3'b111: for (int k = 0; k <= int'(imm); k++) expv += ref_rf[3'(rs1 + 3'(k))] * ref_rf[3'(rs2 + 3'(k))];
                default: expv = '0;
            endcase
            exp_lat = (op == 3'b100) ? 2 : (op == 3'b111) ? int'(imm) + 2 : 1;
            r0 = rd_cnt;
            w0 = wr_cnt;
            run({op, rd, rs1, rs2, imm}, lat, e);
            vectors++;
            if (lat !== exp_lat || e !== (op == 3'b010 || op == 3'b011)) begin
                miscompares++;
                $display("FAIL rand_timing n=%0d op=%0d got lat=%0d err=%b exp lat=%0d", n, op, lat, e, exp_lat);
            end
            if (op == 3'b101) begin
                vectors++;
                if (wr_cnt - w0 !== 1 || last_waddr !== addr || last_wdata !== ref_rf[rd]) begin
                    miscompares++;
                    $display("FAIL rand_str n=%0d got wr=%0d addr=%h data=%h exp wr=1 addr=%h data=%h",
                             n, wr_cnt - w0, last_waddr, last_wdata, addr, ref_rf[rd]);
                end
                mem[addr] = ref_rf[rd];
            end else if (op != 3'b010 && op != 3'b011) begin
                ref_rf[rd] = expv;
                bus.rf_sel = rd; #1;
                vectors++;
                if (bus.rf_data !== expv || rd_cnt - r0 !== (op == 3'b100 ? 1 : 0)) begin
                    miscompares++;
                    $display("FAIL rand_wr n=%0d op=%0d got R%0d=%h rd=%0d exp %h", n, op, rd, bus.rf_data, rd_cnt - r0, expv);
                end
            end
        end
        for (int i = 0; i < 8; i++) begin
            bus.rf_sel = 3'(i); #1;
            vectors++;
            if (bus.rf_data !== ref_rf[i]) begin miscompares++; $display("FAIL rand R%0d got=%h exp=%h", i, bus.rf_data, ref_rf[i]); end
        end
    endtask
    task automatic test_reset_mid;
        int lat, d0;
        logic e;
        bus.instr = mk(3'b111, 3'd0, 3'd1, 3'd2, 4'd15);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        d0 = done_cnt;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_mid_ready got=%b exp=1", bus.in_ready); end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        vectors++;
        if (done_cnt != d0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_done got dones=%0d ready=%b exp dones=0 ready=1", done_cnt - d0, bus.in_ready);
        end
        for (int i = 0; i < 8; i++) begin
            ref_rf[i] = '0;
            bus.rf_sel = 3'(i); #1;
            vectors++;
            if (bus.rf_data !== 32'd0) begin miscompares++; $display("FAIL reset_mid R%0d got=%h exp=0", i, bus.rf_data); end
        end
        load_reg(3'd1, 32'd3);
        run(mk(3'b111, 3'd2, 3'd1, 3'd1, 4'd0), lat, e);
        bus.rf_sel = 3'd2; #1;
        vectors++;
        if (lat !== 2 || bus.rf_data !== 32'd9) begin
            miscompares++;
            $display("FAIL post_reset_dpro got lat=%0d R2=%0d exp lat=2 R2=9", lat, bus.rf_data);
        end
    endtask
    initial begin
        bus.in_valid = 1'b0;
        bus.instr = '0;
        bus.rf_sel = '0;
        for (int k = 0; k < 256; k++) mem[k] = 32'(k + 1);
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_load();
        test_add_str();
        test_dpro();
        test_wrap();
        test_overflow();
        test_illegal();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
